// File: rtl/rw_stage_pkg.sv
// ============================================================================
//  Module      : rw_stage_pkg
//  Description : Shared constants and helpers for the register-writeback stage.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rw_stage_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 4;
    localparam int NUM_REGS = 16;
    localparam int CB_W     = 22;

    // Bit positions inside the decoded control bus
    localparam int CB_IS_WB   = 0;
    localparam int CB_IS_LD   = 1;
    localparam int CB_IS_CALL = 2;

    localparam logic [ADDR_W-1:0] RA_INDEX = 4'd15;
    localparam logic [DATA_W-1:0] PC_INCR  = 32'd4;
    localparam int                RD_MSB   = 25;
    localparam int                RD_LSB   = 22;

    typedef enum logic [1:0] {
        WB_SRC_ALU  = 2'd0,
        WB_SRC_LD   = 2'd1,
        WB_SRC_CALL = 2'd2
    } wb_src_t;

    // CALL outranks LD; anything else writes the ALU result.
    function automatic wb_src_t select_wb_src(input logic [CB_W-1:0] cb);
        wb_src_t src;
        if (cb[CB_IS_CALL]) begin
            src = WB_SRC_CALL;
        end else if (cb[CB_IS_LD]) begin
            src = WB_SRC_LD;
        end else begin
            src = WB_SRC_ALU;
        end
        return src;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rw_regfile.sv
// ============================================================================
//  Module      : rw_regfile
//  Description : 16 x 32 register file, one write port, two write-through reads.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rw_regfile
    import rw_stage_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                we,
    input  logic [ADDR_W-1:0]   waddr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [ADDR_W-1:0]   raddr_a,
    input  logic [ADDR_W-1:0]   raddr_b,
    output logic [DATA_W-1:0]   rdata_a,
    output logic [DATA_W-1:0]   rdata_b
);

    logic [DATA_W-1:0] r_regs [NUM_REGS];
    logic [ADDR_W-1:0] w_raddr [2];
    logic [DATA_W-1:0] w_rdata [2];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (we) begin
            r_regs[waddr] <= wdata;
        end
    end

    assign w_raddr[0] = raddr_a;
    assign w_raddr[1] = raddr_b;

    // A write in flight is forwarded so the reader never sees stale data.
    generate
        for (genvar p = 0; p < 2; p++) begin : g_rd_port
            assign w_rdata[p] = (we && (w_raddr[p] == waddr)) ? wdata
                                                              : r_regs[w_raddr[p]];
        end
    endgenerate

    assign rdata_a = w_rdata[0];
    assign rdata_b = w_rdata[1];

endmodule

`default_nettype wire

// File: rtl/rw_stage.sv
// ============================================================================
//  Module      : rw_stage
//  Description : Register-writeback stage: writeback mux, retire counter, regfile.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rw_stage
    import rw_stage_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                input_RW_valid,
    input  logic [31:0]         input_RW_PC,
    input  logic [31:0]         input_RW_Ld_Result,
    input  logic [31:0]         input_RW_ALU_Result,
    input  logic [31:0]         input_RW_IR,
    input  logic [21:0]         input_RW_controlBus,
    input  logic [3:0]          rd_addr_a,
    input  logic [3:0]          rd_addr_b,
    output logic [31:0]         rd_data_a,
    output logic [31:0]         rd_data_b,
    output logic                wb_en,
    output logic [3:0]          wb_addr,
    output logic [31:0]         wb_data,
    output logic [31:0]         retired_count
);

    logic              w_wb_en;
    logic [3:0]        w_wb_addr;
    logic [31:0]       w_wb_data;
    wb_src_t           w_wb_src;
    logic [31:0]       r_retired_count;

    assign w_wb_en   = input_RW_valid & input_RW_controlBus[CB_IS_WB] & ~rst;
    assign w_wb_addr = input_RW_controlBus[CB_IS_CALL] ? RA_INDEX
                                                       : input_RW_IR[RD_MSB:RD_LSB];
    assign w_wb_src  = select_wb_src(input_RW_controlBus);

    always_comb begin
        w_wb_data = input_RW_ALU_Result;
        case (w_wb_src)
            WB_SRC_CALL: w_wb_data = input_RW_PC + PC_INCR;
            WB_SRC_LD:   w_wb_data = input_RW_Ld_Result;
            default:     w_wb_data = input_RW_ALU_Result;
        endcase
    end

    // Wraps silently at 2^32; no overflow indication is wanted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_retired_count <= '0;
        end else if (input_RW_valid) begin
            r_retired_count <= r_retired_count + 32'd1;
        end
    end

    rw_regfile u_regfile (
        .clk     (clk),
        .rst     (rst),
        .we      (w_wb_en),
        .waddr   (w_wb_addr),
        .wdata   (w_wb_data),
        .raddr_a (rd_addr_a),
        .raddr_b (rd_addr_b),
        .rdata_a (rd_data_a),
        .rdata_b (rd_data_b)
    );

    assign wb_en         = w_wb_en;
    assign wb_addr       = w_wb_addr;
    assign wb_data       = w_wb_data;
    assign retired_count = r_retired_count;

    // Only the rd field of the instruction word is consumed here.
    logic w_unused;
    assign w_unused = ^{input_RW_IR[31:RD_MSB+1], input_RW_IR[RD_LSB-1:0],
                        input_RW_controlBus[21:3]};

endmodule

`default_nettype wire

// File: tb/tb_rw_stage.sv
// ============================================================================
//  Module      : tb_rw_stage
//  Description : Directed self-checking bench for rw_stage.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rw_stage;

    logic        clk;
    logic        rst;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] ld_res;
    logic [31:0] alu_res;
    logic [31:0] ir;
    logic [21:0] cb;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [31:0] rda;
    logic [31:0] rdb;
    logic        wen;
    logic [3:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] rcount;

    int n_total;
    int n_bad;

    localparam logic [21:0] C_WB   = 22'h000001;
    localparam logic [21:0] C_LD   = 22'h000002;
    localparam logic [21:0] C_CALL = 22'h000004;

    rw_stage dut (
        .clk                 (clk),
        .rst                 (rst),
        .input_RW_valid      (valid),
        .input_RW_PC         (pc),
        .input_RW_Ld_Result  (ld_res),
        .input_RW_ALU_Result (alu_res),
        .input_RW_IR         (ir),
        .input_RW_controlBus (cb),
        .rd_addr_a           (ra),
        .rd_addr_b           (rb),
        .rd_data_a           (rda),
        .rd_data_b           (rdb),
        .wb_en               (wen),
        .wb_addr             (waddr),
        .wb_data             (wdata),
        .retired_count       (rcount)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // rd lands in IR[25:22]; surrounding bits are filled with noise.
    task automatic drive(input logic v, input logic [31:0] p, input logic [31:0] ld,
                         input logic [31:0] alu, input logic [3:0] rd, input logic [21:0] c);
        valid   = v;
        pc      = p;
        ld_res  = ld;
        alu_res = alu;
        ir      = {6'h2A, rd, 22'h15555};
        cb      = c;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic read_pair(input logic [3:0] a, input logic [3:0] b);
        ra = a;
        rb = b;
        #1;
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        rst = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 32'h0, 4'd0, 22'h0);
        ra = 4'd0;
        rb = 4'd0;
        step();
        step();
        rst = 1'b0;
        #1;

        // Reset state: every register and the counter read zero
        check("reset_count", rcount, 32'h0);
        check("reset_wb_en", {31'h0, wen}, 32'h0);
        for (int i = 0; i < 16; i++) begin
            read_pair(4'(i), 4'(15 - i));
            check($sformatf("reset_ra_r%0d", i), rda, 32'h0);
            check($sformatf("reset_rb_r%0d", 15 - i), rdb, 32'h0);
        end

        // ALU write r3 with same-cycle bypass
        drive(1'b1, 32'h0, 32'hCAFE0000, 32'h12345678, 4'd3, C_WB);
        read_pair(4'd3, 4'd4);
        check("alu_bypass_a", rda, 32'h12345678);
        check("alu_other_b", rdb, 32'h0);
        check("alu_wb_en", {31'h0, wen}, 32'h1);
        check("alu_wb_addr", {28'h0, waddr}, 32'd3);
        check("alu_wb_data", wdata, 32'h12345678);
        step();
        drive(1'b0, 32'h0, 32'h0, 32'h0, 4'd0, 22'h0);
        #1;
        check("alu_stored", rda, 32'h12345678);
        check("alu_count", rcount, 32'd1);

        // Load into r7 picks the load result over the ALU result
        drive(1'b1, 32'h0, 32'hDEADBEEF, 32'h00000100, 4'd7, C_WB | C_LD);
        read_pair(4'd7, 4'd3);
        check("ld_wb_data", wdata, 32'hDEADBEEF);
        check("ld_bypass_a", rda, 32'hDEADBEEF);
        check("ld_b_r3", rdb, 32'h12345678);
        step();
        drive(1'b0, 32'h0, 32'h0, 32'h0, 4'd0, 22'h0);
        #1;
        check("ld_stored", rda, 32'hDEADBEEF);

        // Call with LD also set: CALL wins, writes PC+4 to r15
        drive(1'b1, 32'h40, 32'h11111111, 32'h22222222, 4'd2, C_WB | C_LD | C_CALL);
        read_pair(4'd15, 4'd2);
        check("call_wb_addr", {28'h0, waddr}, 32'd15);
        check("call_wb_data", wdata, 32'h44);
        check("call_bypass_ra", rda, 32'h44);
        check("call_r2_b", rdb, 32'h0);
        step();
        drive(1'b0, 32'h0, 32'h0, 32'h0, 4'd0, 22'h0);
        #1;
        check("call_r15", rda, 32'h44);
        check("call_r2", rdb, 32'h0);
        check("call_count", rcount, 32'd3);

        // Store (no WB) then three bubbles carrying write-like noise
        drive(1'b1, 32'h80, 32'hAAAA5555, 32'hFFFF0000, 4'd3, C_LD);
        read_pair(4'd3, 4'd7);
        check("st_wb_en", {31'h0, wen}, 32'h0);
        check("st_no_bypass", rda, 32'h12345678);
        step();
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 32'h100, 32'h5A5A5A5A, 32'hA5A5A5A5, 4'(k + 7), C_WB);
            read_pair(4'(k + 7), 4'd3);
            check($sformatf("idle%0d_wb_en", k), {31'h0, wen}, 32'h0);
            step();
        end
        read_pair(4'd3, 4'd7);
        check("st_r3", rda, 32'h12345678);
        check("st_r7", rdb, 32'hDEADBEEF);
        read_pair(4'd8, 4'd9);
        check("st_r8", rda, 32'h0);
        check("st_r9", rdb, 32'h0);
        check("st_count", rcount, 32'd4);

        // Counter wrap: preload all-ones, then retire one nop
        force dut.r_retired_count = 32'hFFFF_FFFF;
        #1;
        release dut.r_retired_count;
        drive(1'b1, 32'h0, 32'h0, 32'h0, 4'd0, 22'h0);
        step();
        drive(1'b0, 32'h0, 32'h0, 32'h0, 4'd0, 22'h0);
        #1;
        check("wrap_count", rcount, 32'h0);

        // Reset coincident with a valid write to r5
        rst = 1'b1;
        drive(1'b1, 32'h0, 32'h0, 32'hA5A5A5A5, 4'd5, C_WB);
        read_pair(4'd5, 4'd3);
        check("rst_wb_en", {31'h0, wen}, 32'h0);
        check("rst_ra_r5", rda, 32'h0);
        check("rst_rb_r3_pre", rdb, 32'h12345678);
        step();
        rst = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 32'h0, 4'd0, 22'h0);
        #1;
        check("rst_r5", rda, 32'h0);
        check("rst_r3", rdb, 32'h0);
        check("rst_count", rcount, 32'h0);

        // First edge out of reset accepts an instruction
        drive(1'b1, 32'h0, 32'h0, 32'h0BADF00D, 4'd9, C_WB);
        step();
        drive(1'b0, 32'h0, 32'h0, 32'h0, 4'd0, 22'h0);
        read_pair(4'd9, 4'd15);
        check("post_rst_r9", rda, 32'h0BADF00D);
        check("post_rst_r15", rdb, 32'h0);
        check("post_rst_count", rcount, 32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rw_stage.md
RW_STAGE -- requirements
Module: rw_stage

Interface
REQ-001 clk  input  1  pipeline clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 input_RW_valid  input  1  an instruction is present in the MA/RW latch this cycle.
REQ-004 input_RW_PC  input  32  PC of the instruction in RW.
REQ-005 input_RW_Ld_Result  input  32  data returned by the memory-access stage.
REQ-006 input_RW_ALU_Result  input  32  ALU result carried from execute.
REQ-007 input_RW_IR  input  32  instruction word; rd = IR[25:22].
REQ-008 input_RW_controlBus  input  22  decoded control bits; bit positions are shared-package constants.
REQ-009 rd_addr_a, rd_addr_b  input  4 each  register-file read addresses from operand fetch.
REQ-010 rd_data_a, rd_data_b  output  32 each  register read data, bypassed (REQ-016).
REQ-011 wb_en  output  1  a register write occurs at the next rising edge.
REQ-012 wb_addr  output  4  destination register of the current write.
REQ-013 wb_data  output  32  value being written, for forwarding.
REQ-014 retired_count  output  32  count of valid instructions retired.

Function
REQ-015 Register file: 16 x 32-bit registers r0..r15, r15 = return address (ra); r0 is writable and has no special meaning.
REQ-016 Reads are combinational; if wb_en=1 and the read address equals wb_addr, rd_data returns wb_data (write-through); otherwise it returns the stored value.
REQ-017 wb_en = input_RW_valid AND controlBus[CB_IS_WB] AND NOT rst.
REQ-018 wb_addr = 15 if controlBus[CB_IS_CALL]=1, else IR[25:22].
REQ-019 wb_data priority: CB_IS_CALL -> input_RW_PC + 4 (mod 2^32); else CB_IS_LD -> input_RW_Ld_Result; else input_RW_ALU_Result.
REQ-020 When wb_en=1, register[wb_addr] <= wb_data at the rising edge; exactly one write per cycle at most.
REQ-021 Instructions with CB_IS_WB=0 (store, branch, nop, cmp) cause no register write but still retire.
REQ-022 retired_count increments by 1 on each rising edge with input_RW_valid=1 and rst=0; it wraps from 0xFFFFFFFF to 0x00000000 with no flag.
REQ-023 input_RW_valid=0: no write, no count, bypass inactive; all other inputs are ignored.
REQ-024 Latency: a write is visible through bypass in the same cycle and from storage in the following cycle; no stalls and no backpressure.
REQ-025 CB_IS_CALL and CB_IS_LD both set: CALL takes precedence (REQ-019).

Reset
REQ-026 While rst=1 at a rising edge, all 16 registers clear to 0 and retired_count clears to 0.
REQ-027 During rst=1, wb_en=0 and any pending write or retirement in that cycle is discarded.
REQ-028 When rst=1, rd_data_a and rd_data_b return stored (pre-clear) values combinationally and are 0 from the cycle after reset onward.
REQ-029 The first valid instruction is accepted on the first rising edge with rst=0.

Structure
REQ-030 Shared package: CB_IS_WB, CB_IS_LD, CB_IS_CALL bit indices; RA_INDEX=15; PC_INCR=4; RD_MSB=25, RD_LSB=22; NUM_REGS=16.
REQ-031 The register storage plus bypass read ports form a single sub-module, rw_regfile; the writeback mux, address select and counter are in rw_stage.

Verification
REQ-032 Reset, then read all 16 addresses -> each rd_data = 0 and retired_count = 0.
REQ-033 Valid ALU op with rd=3, ALU_Result=0x12345678, WB=1; rd_addr_a=3 in the same cycle -> rd_data_a=0x12345678 (bypass), wb_en=1; next cycle stored value = 0x12345678, retired_count=1.
REQ-034 Valid load with rd=7, Ld_Result=0xDEADBEEF, ALU_Result=0x100 -> r7=0xDEADBEEF; call with PC=0x40, IR rd field=2 -> r15=0x44 and r2 unchanged.
REQ-035 Valid store (WB=0), then valid=0 for 3 cycles -> no register changes; retired_count +1 only.
REQ-036 Force retired_count to 0xFFFFFFFF via 2^32-1 retirements (or a preloaded test hook), then one more valid instruction -> count=0.
REQ-037 Assert rst in the same cycle as a valid write to r5=0xA5A5A5A5 -> wb_en=0; after reset r5=0 and retired_count=0.
